// File: rtl/ntwrk_cmd_gen.sv
// ntwrk_cmd_gen: turns a distance-sorted connection stream into network-size commands.
// Each point gets a network id. A point->network table is looked up once per connection, and
// the resulting command (NEW/WR_A/WR_B/MERGE/IGNORE) is issued downstream.
// Optional feature macro: NTWRK_SERIAL_RELABEL_EN. When it is defined, a MERGE relabels table
// entries one per cycle in a RELABEL state. Otherwise all entries are relabelled in parallel.
// i_conn layout: {distance[DIST_W-1:0], pointa[PtW-1:0], pointb[PtW-1:0]}.
// o_cmd layout:  {ntwrkb[IdW-1:0], ntwrka[IdW-1:0], op[2:0]}.
// Op encoding:   NEW=0, WR_A=1, WR_B=2, MERGE=3, IGNORE=4.
module ntwrk_cmd_gen #(
  parameter int unsigned NUM_POINTS = 8,
  parameter int unsigned NUM_CONNS  = 6,
  parameter int unsigned DIST_W     = 32,
  localparam int unsigned PtW   = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1,
  localparam int unsigned IdW   = (NUM_CONNS > 1) ? $clog2(NUM_CONNS) : 1,
  localparam int unsigned CntW  = $clog2(NUM_CONNS + 1),
  localparam int unsigned ConnW = DIST_W + 2 * PtW,
  localparam int unsigned CmdW  = 2 * IdW + 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_conn_valid,
  output logic             o_conn_ready,
  input  logic [ConnW-1:0] i_conn,
  output logic             o_cmd_valid,
  input  logic             i_cmd_ready,
  output logic [CmdW-1:0]  o_cmd,
  output logic [CntW-1:0]  o_conn_cnt,
  output logic             o_done
);

  typedef enum logic [2:0] {
    CmdNew    = 3'd0,
    CmdWrA    = 3'd1,
    CmdWrB    = 3'd2,
    CmdMerge  = 3'd3,
    CmdIgnore = 3'd4
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLookup  = 2'd1,
    StIssue   = 2'd2,
    StRelabel = 2'd3
  } state_e;

  state_e          r_state, w_state_d;
  logic [PtW-1:0]  r_pa, r_pb;
  cmd_op_e         r_op, w_op;
  logic [IdW-1:0]  r_ida, r_idb, w_ida, w_idb;
  logic [IdW-1:0]  r_next_id;
  logic [CntW-1:0] r_cnt;
  logic            r_done;

  // Point -> network table
  logic            r_vld [NUM_POINTS];
  logic [IdW-1:0]  r_id  [NUM_POINTS];

  logic            w_ea_vld, w_eb_vld;
  logic [IdW-1:0]  w_ea_id, w_eb_id;
  logic            w_accept, w_hs;
  logic            w_unused_dist;

`ifdef NTWRK_SERIAL_RELABEL_EN
  logic [PtW-1:0]  r_idx;
`endif

  assign w_unused_dist = ^i_conn[ConnW-1:2*PtW];

  assign o_conn_ready = (r_state == StIdle) && !r_done;
  assign o_cmd_valid  = (r_state == StIssue);
  assign o_cmd        = {r_idb, r_ida, r_op};
  assign o_conn_cnt   = r_cnt;
  assign o_done       = r_done;

  assign w_accept = i_conn_valid && o_conn_ready;
  assign w_hs     = (r_state == StIssue) && i_cmd_ready;

  assign w_ea_vld = r_vld[r_pa];
  assign w_eb_vld = r_vld[r_pb];
  assign w_ea_id  = r_id[r_pa];
  assign w_eb_id  = r_id[r_pb];

  // Command decode from the two table entries of the latched connection
  always_comb begin
    w_op  = CmdIgnore;
    w_ida = '0;
    w_idb = '0;
    if (r_pa == r_pb) begin
      w_op  = CmdIgnore;
      w_ida = w_ea_vld ? w_ea_id : '0;
      w_idb = w_ida;
    end else if (!w_ea_vld && !w_eb_vld) begin
      w_op  = CmdNew;
      w_ida = r_next_id;
      w_idb = r_next_id;
    end else if (w_ea_vld && !w_eb_vld) begin
      w_op  = CmdWrB;
      w_ida = w_ea_id;
      w_idb = w_ea_id;
    end else if (!w_ea_vld && w_eb_vld) begin
      w_op  = CmdWrA;
      w_ida = w_eb_id;
      w_idb = w_eb_id;
    end else if (w_ea_id == w_eb_id) begin
      w_op  = CmdIgnore;
      w_ida = w_ea_id;
      w_idb = w_ea_id;
    end else begin
      w_op  = CmdMerge;
      w_ida = w_ea_id;
      w_idb = w_eb_id;
    end
  end

  // FSM next-state
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (w_accept) w_state_d = StLookup;
      StLookup: w_state_d = StIssue;
      StIssue: begin
        if (i_cmd_ready) begin
`ifdef NTWRK_SERIAL_RELABEL_EN
          w_state_d = (r_op == CmdMerge) ? StRelabel : StIdle;
`else
          w_state_d = StIdle;
`endif
        end
      end
`ifdef NTWRK_SERIAL_RELABEL_EN
      StRelabel: if (r_idx == PtW'(NUM_POINTS - 1)) w_state_d = StIdle;
`endif
      default:  w_state_d = StIdle;
    endcase
  end

  // Control registers: state, latched points, registered command, counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_pa      <= '0;
      r_pb      <= '0;
      r_op      <= CmdNew;
      r_ida     <= '0;
      r_idb     <= '0;
      r_next_id <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_pa <= i_conn[2*PtW-1:PtW];
        r_pb <= i_conn[PtW-1:0];
      end
      if (r_state == StLookup) begin
        r_op  <= w_op;
        r_ida <= w_ida;
        r_idb <= w_idb;
      end
      if (w_hs) begin
        r_cnt <= r_cnt + CntW'(1);
        if (r_cnt == CntW'(NUM_CONNS - 1)) r_done <= 1'b1;
        if (r_op == CmdNew) r_next_id <= r_next_id + IdW'(1);
      end
    end
  end

`ifdef NTWRK_SERIAL_RELABEL_EN
  // Relabel walk index: restarts on every handshake, advances while relabelling
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
    end else if (w_hs) begin
      r_idx <= '0;
    end else if (r_state == StRelabel) begin
      r_idx <= r_idx + PtW'(1);
    end
  end
`endif

  // Table updates: all writes land on the command handshake edge (or during relabel)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(NUM_POINTS); i++) begin
        r_vld[i] <= 1'b0;
        r_id[i]  <= '0;
      end
    end else if (w_hs) begin
      case (r_op)
        CmdNew: begin
          r_vld[r_pa] <= 1'b1;
          r_id[r_pa]  <= r_ida;
          r_vld[r_pb] <= 1'b1;
          r_id[r_pb]  <= r_ida;
        end
        CmdWrA: begin
          r_vld[r_pa] <= 1'b1;
          r_id[r_pa]  <= r_ida;
        end
        CmdWrB: begin
          r_vld[r_pb] <= 1'b1;
          r_id[r_pb]  <= r_ida;
        end
`ifndef NTWRK_SERIAL_RELABEL_EN
        CmdMerge: begin
          for (int i = 0; i < int'(NUM_POINTS); i++) begin
            if (r_vld[i] && (r_id[i] == r_idb)) r_id[i] <= r_ida;
          end
        end
`endif
        default: ;
      endcase
`ifdef NTWRK_SERIAL_RELABEL_EN
    end else if (r_state == StRelabel) begin
      if (r_vld[r_idx] && (r_id[r_idx] == r_idb)) r_id[r_idx] <= r_ida;
`endif
    end
  end

  // Every NEW hands out an id that fits the NUM_CONNS id space
  a_next_id_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (w_hs && (r_op == CmdNew)) |-> (r_next_id <= IdW'(NUM_CONNS - 1)));

endmodule

// File: tb/tb_ntwrk_cmd_gen.sv
// Directed bench for ntwrk_cmd_gen (NUM_POINTS=8, NUM_CONNS=6).
// Vector tables are applied in loops; stall, done, and reset corners are hand-written sequences.
module tb_ntwrk_cmd_gen;

  localparam int NumPoints = 8;
  localparam int NumConns  = 6;
  localparam int DistW     = 32;
  localparam int ConnW     = DistW + 6;
  localparam int CmdW      = 9;

  localparam logic [2:0] OpNew    = 3'd0;
  localparam logic [2:0] OpWrA    = 3'd1;
  localparam logic [2:0] OpWrB    = 3'd2;
  localparam logic [2:0] OpMerge  = 3'd3;
  localparam logic [2:0] OpIgnore = 3'd4;

`ifdef NTWRK_SERIAL_RELABEL_EN
  localparam int RelabelGap = NumPoints;
`else
  localparam int RelabelGap = 0;
`endif

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] stall;
    logic [2:0] op;
    logic [2:0] ida;
    logic [2:0] idb;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             conn_valid;
  logic             conn_ready;
  logic [ConnW-1:0] conn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CmdW-1:0]  cmd;
  logic [2:0]       conn_cnt;
  logic             done;

  int total = 0;
  int bad   = 0;

  vec_t seq1 [6];
  vec_t seq2 [6];

  ntwrk_cmd_gen #(
    .NUM_POINTS(NumPoints),
    .NUM_CONNS (NumConns),
    .DIST_W    (DistW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_conn_valid(conn_valid),
    .o_conn_ready(conn_ready),
    .i_conn      (conn),
    .o_cmd_valid (cmd_valid),
    .i_cmd_ready (cmd_ready),
    .o_cmd       (cmd),
    .o_conn_cnt  (conn_cnt),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    conn_valid = 1'b0;
    cmd_ready  = 1'b1;
    conn       = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst conn_ready", int'(conn_ready), 1);
    chk("rst cmd_valid", int'(cmd_valid), 0);
    chk("rst conn_cnt", int'(conn_cnt), 0);
    chk("rst done", int'(done), 0);
    chk("rst cmd", int'(cmd), 0);
  endtask

  // Entry and exit are on a negedge; exp_cnt is conn_cnt after this handshake
  task automatic run_vec(input string tag, input vec_t v, input int exp_cnt);
    int n;
    logic [CmdW-1:0] exp_cmd;
    exp_cmd    = {v.idb, v.ida, v.op};
    conn_valid = 1'b1;
    conn       = {$urandom, v.a, v.b};
    n = 0;
    while (!conn_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " accept"}, int'(conn_ready), 1);
    @(negedge clk);
    conn_valid = 1'b0;
    chk({tag, " lookup cmd_valid"}, int'(cmd_valid), 0);
    if (v.stall != 0) cmd_ready = 1'b0;
    @(negedge clk);
    chk({tag, " latency cmd_valid"}, int'(cmd_valid), 1);
    chk({tag, " cmd"}, int'(cmd), int'(exp_cmd));
    for (int k = 0; k < int'(v.stall); k++) begin
      @(negedge clk);
      chk($sformatf("%s stall%0d cmd_valid", tag, k), int'(cmd_valid), 1);
      chk($sformatf("%s stall%0d cmd", tag, k), int'(cmd), int'(exp_cmd));
      chk($sformatf("%s stall%0d conn_ready", tag, k), int'(conn_ready), 0);
      chk($sformatf("%s stall%0d conn_cnt", tag, k), int'(conn_cnt), exp_cnt - 1);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    chk({tag, " conn_cnt"}, int'(conn_cnt), exp_cnt);
    chk({tag, " done"}, int'(done), (exp_cnt == NumConns) ? 1 : 0);
    chk({tag, " cmd_valid low"}, int'(cmd_valid), 0);
    if (exp_cnt < NumConns) begin
      n = 0;
      while (!conn_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk({tag, " ready gap"}, n, (v.op == OpMerge) ? RelabelGap : 0);
    end else begin
      chk({tag, " conn_ready after done"}, int'(conn_ready), 0);
    end
  endtask

  initial begin
    //            a     b     stall  op        ida   idb
    seq1[0] = '{3'd0, 3'd1, 4'd0, OpNew,    3'd0, 3'd0};
    seq1[1] = '{3'd2, 3'd3, 4'd0, OpNew,    3'd1, 3'd1};
    seq1[2] = '{3'd1, 3'd4, 4'd5, OpWrB,    3'd0, 3'd0};
    seq1[3] = '{3'd5, 3'd2, 4'd0, OpWrA,    3'd1, 3'd1};
    seq1[4] = '{3'd4, 3'd0, 4'd0, OpIgnore, 3'd0, 3'd0};
    seq1[5] = '{3'd3, 3'd1, 4'd0, OpMerge,  3'd1, 3'd0};
    // Merge mid-stream; the later vectors expose whether 2,3 were relabelled to 0
    seq2[0] = '{3'd0, 3'd1, 4'd0, OpNew,    3'd0, 3'd0};
    seq2[1] = '{3'd2, 3'd3, 4'd0, OpNew,    3'd1, 3'd1};
    seq2[2] = '{3'd0, 3'd2, 4'd0, OpMerge,  3'd0, 3'd1};
    seq2[3] = '{3'd3, 3'd5, 4'd0, OpWrB,    3'd0, 3'd0};
    seq2[4] = '{3'd1, 3'd3, 4'd0, OpIgnore, 3'd0, 3'd0};
    seq2[5] = '{3'd6, 3'd7, 4'd0, OpNew,    3'd2, 3'd2};

    do_reset();
    for (int i = 0; i < 6; i++) run_vec($sformatf("s1v%0d", i), seq1[i], i + 1);

    // After done, a pending connection must not be accepted
    conn_valid = 1'b1;
    conn       = {32'd0, 3'd6, 3'd7};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("done hold%0d conn_ready", k), int'(conn_ready), 0);
      chk($sformatf("done hold%0d cmd_valid", k), int'(cmd_valid), 0);
      chk($sformatf("done hold%0d conn_cnt", k), int'(conn_cnt), NumConns);
    end
    conn_valid = 1'b0;

    do_reset();
    for (int i = 0; i < 6; i++) run_vec($sformatf("s2v%0d", i), seq2[i], i + 1);

    // Self-connection on an empty table, then allocation is still from id 0
    do_reset();
    run_vec("s3 self", '{3'd6, 3'd6, 4'd0, OpIgnore, 3'd0, 3'd0}, 1);
    run_vec("s3 new67", '{3'd6, 3'd7, 4'd0, OpNew, 3'd0, 3'd0}, 2);
    run_vec("s3 new01", '{3'd0, 3'd1, 4'd0, OpNew, 3'd1, 3'd1}, 3);

    // Reset while a command is stalled in ISSUE
    conn_valid = 1'b1;
    conn       = {32'd7, 3'd0, 3'd1};
    begin
      int n;
      n = 0;
      while (!conn_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    conn_valid = 1'b0;
    cmd_ready  = 1'b0;
    @(negedge clk);
    chk("midrst cmd_valid before", int'(cmd_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst cmd_valid", int'(cmd_valid), 0);
    chk("midrst conn_cnt", int'(conn_cnt), 0);
    chk("midrst done", int'(done), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    cmd_ready = 1'b1;
    @(negedge clk);
    run_vec("s3 post-reset", '{3'd0, 3'd1, 4'd0, OpNew, 3'd0, 3'd0}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
